tt_mux_sel_ctrl: RTL



---
 rtl/tt_mux_ctrl_pkg.sv | 25 ++
 rtl/tt_mux_wb_regs.sv | 72 +++++++
 rtl/tt_mux_sel_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tt_mux_ctrl_pkg.sv
// rtl/tt_mux_ctrl_pkg.sv - shared states and register constants for the Tiny Tapeout mux sequencer
package tt_mux_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_GAP    = 3'd2,
    ST_INC_HI = 3'd3,
    ST_INC_LO = 3'd4,
    ST_ENA    = 3'd5
  } mux_state_t;

  localparam logic [1:0] REG_SEL    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ENA_AFTER = 1;
  localparam int CTRL_ABORT     = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ADDR_LSB = 16;

endpackage

// File: rtl/tt_mux_wb_regs.sv
// rtl/tt_mux_wb_regs.sv - wishbone decode, zero-wait ack, SEL register and CTRL command pulses
module tt_mux_wb_regs
  import tt_mux_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              busy,
  input  logic              done,
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] sel,
  output logic              start_req,
  output logic              abort_req,
  output logic              ena_after_req
);

  logic        req;
  logic        wr;
  logic [1:0]  reg_idx;
  logic [31:0] rdata;
  logic        unused_bits;

  // A new request is only taken when no ack is pending, so back-to-back strobes ack every other cycle
  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];

  // Command pulses act on the accept edge itself
  assign start_req     = wr && (reg_idx == REG_CTRL) && wbs_dat_i[CTRL_START];
  assign abort_req     = wr && (reg_idx == REG_CTRL) && wbs_dat_i[CTRL_ABORT];
  assign ena_after_req = wbs_dat_i[CTRL_ENA_AFTER];

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:ADDR_W]};

  // Read mux; CTRL and the spare slot read back as zero
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_SEL: rdata[ADDR_W-1:0] = sel;
      REG_STATUS: begin
        rdata[STAT_BUSY]                = busy;
        rdata[STAT_DONE]                = done;
        rdata[STAT_ADDR_LSB +: ADDR_W]  = cur_addr;
      end
      default: rdata = '0;
    endcase
  end

  // Registered ack and read data, plus the SEL register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      sel       <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
      if (wr && (reg_idx == REG_SEL)) begin
        sel <= wbs_dat_i[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// rtl/tt_mux_sel_ctrl.sv - sequencer that resets, steps and enables the Tiny Tapeout design mux
module tt_mux_sel_ctrl
  import tt_mux_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int PULSE_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ctrl_sel_rst_n,
  output logic        ctrl_sel_inc,
  output logic        ctrl_ena,
  output logic        busy
);

  localparam int               CNT_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mux_state_t        state;
  mux_state_t        next_state;
  logic [CNT_W-1:0]  cnt;
  logic              timer_done;
  logic [ADDR_W-1:0] sel;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W:0]   next_addr;
  logic              ena_after_q;
  logic              done_q;
  logic              start_req;
  logic              abort_req;
  logic              ena_after_req;
  logic              start_acc;
  logic              enter_ena;

  tt_mux_wb_regs #(
    .ADDR_W(ADDR_W)
  ) u_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .busy         (busy),
    .done         (done_q),
    .cur_addr     (cur_addr_q),
    .sel          (sel),
    .start_req    (start_req),
    .abort_req    (abort_req),
    .ena_after_req(ena_after_req)
  );

  // One bit wider than the counter so an all-ones target compares before any wrap
  assign next_addr  = {1'b0, cur_addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign timer_done = (cnt == '0);
  assign start_acc  = (state == ST_IDLE) && start_req && !abort_req;
  assign enter_ena  = (next_state == ST_ENA) && (state != ST_ENA);

  // State register plus the shared phase timer, reloaded on every state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        cnt <= CNT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Next-state decode; abort overrides everything including a simultaneous start
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_req) next_state = ST_RST;
      ST_RST:    if (timer_done) next_state = ST_GAP;
      ST_GAP:    if (timer_done) next_state = (target_q != '0) ? ST_INC_HI : ST_ENA;
      ST_INC_HI: if (timer_done) next_state = ST_INC_LO;
      ST_INC_LO: if (timer_done) next_state = (next_addr < {1'b0, target_q}) ? ST_INC_HI : ST_ENA;
      ST_ENA:    next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    if (abort_req) begin
      next_state = ST_IDLE;
    end
  end

  // Mux control lines are registered from the next state so they never glitch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q       <= '0;
      ena_after_q    <= 1'b0;
      done_q         <= 1'b0;
      cur_addr_q     <= '0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      ctrl_sel_rst_n <= (next_state != ST_RST);
      ctrl_sel_inc   <= (next_state == ST_INC_HI);
      busy           <= (next_state != ST_IDLE);
      if (start_acc) begin
        target_q    <= sel;
        ena_after_q <= ena_after_req;
        done_q      <= 1'b0;
        cur_addr_q  <= '0;
      end
      if ((state == ST_INC_LO) && timer_done && !abort_req) begin
        cur_addr_q <= next_addr[ADDR_W-1:0];
      end
      if (abort_req || start_acc) begin
        ctrl_ena <= 1'b0;
      end else if (enter_ena) begin
        ctrl_ena <= ena_after_q;
      end
      if (enter_ena) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule
